// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory, absorbs the in-flight response in a one-entry skid on stall, and feeds IF/ID.
module fetch_stage #(
  parameter int unsigned         XLEN     = 19,
  parameter logic [XLEN-1:0]     RESET_PC = 19'h00000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_d,
  input  logic            pcsrc_e,
  input  logic [XLEN-1:0] pctarget_e,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus1_d,
  output logic            valid_d
);

  typedef enum logic [1:0] {
    MODE_NORMAL,
    MODE_STALL,
    MODE_REDIRECT
  } mode_e;

  mode_e mode;

  logic [XLEN-1:0] pc_f_q,        pc_f_d;
  logic            rsp_valid_q,   rsp_valid_d;
  logic [XLEN-1:0] rsp_pc_q,      rsp_pc_d;
  logic            skid_valid_q,  skid_valid_d;
  logic [XLEN-1:0] skid_instr_q,  skid_instr_d;
  logic [XLEN-1:0] skid_pc_q,     skid_pc_d;
  logic            ifid_valid_q,  ifid_valid_d;
  logic [XLEN-1:0] ifid_instr_q,  ifid_instr_d;
  logic [XLEN-1:0] ifid_pc_q,     ifid_pc_d;
  logic [XLEN-1:0] ifid_pcp1_q,   ifid_pcp1_d;

  logic            cand_valid;
  logic [XLEN-1:0] cand_instr;
  logic [XLEN-1:0] cand_pc;

  // Redirect outranks stall; reset is applied on top in the register process.
  always_comb begin
    if (pcsrc_e)      mode = MODE_REDIRECT;
    else if (stall_d) mode = MODE_STALL;
    else              mode = MODE_NORMAL;
  end

  // Skid holds the older instruction, so it is always presented first.
  always_comb begin
    cand_valid = skid_valid_q | rsp_valid_q;
    cand_instr = skid_valid_q ? skid_instr_q : imem_rdata;
    cand_pc    = skid_valid_q ? skid_pc_q    : rsp_pc_q;
  end

  always_comb begin
    pc_f_d       = pc_f_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_pc_d     = rsp_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pcp1_d  = ifid_pcp1_q;

    unique case (mode)
      MODE_REDIRECT: begin
        pc_f_d       = pctarget_e;
        rsp_valid_d  = 1'b0;
        skid_valid_d = 1'b0;
        ifid_valid_d = 1'b0;
      end
      MODE_STALL: begin
        rsp_valid_d = 1'b0;
        if (rsp_valid_q) begin
          skid_valid_d = 1'b1;
          skid_instr_d = imem_rdata;
          skid_pc_d    = rsp_pc_q;
        end
      end
      default: begin
        rsp_pc_d     = pc_f_q;
        rsp_valid_d  = 1'b1;
        pc_f_d       = pc_f_q + XLEN'(1);
        skid_valid_d = 1'b0;
        if (cand_valid) begin
          ifid_valid_d = 1'b1;
          ifid_instr_d = cand_instr;
          ifid_pc_d    = cand_pc;
          ifid_pcp1_d  = cand_pc + XLEN'(1);
        end else begin
          ifid_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_f_q       <= RESET_PC;
      rsp_valid_q  <= 1'b0;
      rsp_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_pcp1_q  <= '0;
    end else begin
      pc_f_q       <= pc_f_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_pc_q     <= rsp_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pcp1_q  <= ifid_pcp1_d;
    end
  end

  assign imem_en   = rst && (mode == MODE_NORMAL);
  assign imem_addr = pc_f_q;
  assign instr_d   = ifid_instr_q;
  assign pc_d      = ifid_pc_q;
  assign pcplus1_d = ifid_pcp1_q;
  assign valid_d   = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table from reset through
// stalls, redirects and PC wrap, followed by a mid-stream reset sequence.
module tb_fetch_stage;

  localparam int unsigned XLEN = 19;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall_d;
  logic            pcsrc_e;
  logic [XLEN-1:0] pctarget_e;
  logic            imem_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pcplus1_d;
  logic            valid_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(XLEN), .RESET_PC(19'h00000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_d    (stall_d),
    .pcsrc_e    (pcsrc_e),
    .pctarget_e (pctarget_e),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pcplus1_d  (pcplus1_d),
    .valid_d    (valid_d)
  );

  // Instruction memory contents: imem[a] = 0x40000 + a (truncated to XLEN).
  function automatic logic [XLEN-1:0] memword(input logic [XLEN-1:0] a);
    logic [XLEN-1:0] base;
    base = 19'h40000;
    return base + a;
  endfunction

  initial imem_rdata = '0;
  always @(posedge clk) if (imem_en) imem_rdata <= memword(imem_addr);

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic            stall;
    logic            pcsrc;
    logic [XLEN-1:0] target;
    logic            exp_en;
    logic [XLEN-1:0] exp_addr;
    logic            exp_valid;
    logic [XLEN-1:0] exp_pc;
  } vec_t;

  localparam int unsigned NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic s, input logic r, input logic [XLEN-1:0] t,
                              input logic en, input logic [XLEN-1:0] a,
                              input logic v, input logic [XLEN-1:0] p);
    vec_t x;
    x.stall = s; x.pcsrc = r; x.target = t;
    x.exp_en = en; x.exp_addr = a; x.exp_valid = v; x.exp_pc = p;
    return x;
  endfunction

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            stall pcsrc target    en addr      valid pc (after edge)
    vecs[0]  = mk(0, 0, 19'h0,      1, 19'h00000, 0, 19'h0);
    vecs[1]  = mk(0, 0, 19'h0,      1, 19'h00001, 1, 19'h00000);
    vecs[2]  = mk(0, 0, 19'h0,      1, 19'h00002, 1, 19'h00001);
    vecs[3]  = mk(0, 0, 19'h0,      1, 19'h00003, 1, 19'h00002);
    vecs[4]  = mk(0, 0, 19'h0,      1, 19'h00004, 1, 19'h00003);
    vecs[5]  = mk(1, 0, 19'h0,      0, 19'h00005, 1, 19'h00003); // 1-cycle stall
    vecs[6]  = mk(0, 0, 19'h0,      1, 19'h00005, 1, 19'h00004);
    vecs[7]  = mk(0, 0, 19'h0,      1, 19'h00006, 1, 19'h00005);
    vecs[8]  = mk(1, 0, 19'h0,      0, 19'h00007, 1, 19'h00005); // 4-cycle stall
    vecs[9]  = mk(1, 0, 19'h0,      0, 19'h00007, 1, 19'h00005);
    vecs[10] = mk(1, 0, 19'h0,      0, 19'h00007, 1, 19'h00005);
    vecs[11] = mk(1, 0, 19'h0,      0, 19'h00007, 1, 19'h00005);
    vecs[12] = mk(0, 0, 19'h0,      1, 19'h00007, 1, 19'h00006);
    vecs[13] = mk(0, 0, 19'h0,      1, 19'h00008, 1, 19'h00007);
    vecs[14] = mk(0, 0, 19'h0,      1, 19'h00009, 1, 19'h00008);
    vecs[15] = mk(0, 1, 19'h00100,  0, 19'h0000A, 0, 19'h0);     // redirect
    vecs[16] = mk(0, 0, 19'h0,      1, 19'h00100, 0, 19'h0);
    vecs[17] = mk(0, 0, 19'h0,      1, 19'h00101, 1, 19'h00100);
    vecs[18] = mk(0, 0, 19'h0,      1, 19'h00102, 1, 19'h00101);
    vecs[19] = mk(1, 0, 19'h0,      0, 19'h00103, 1, 19'h00101); // fills skid
    vecs[20] = mk(1, 1, 19'h00200,  0, 19'h00103, 0, 19'h0);     // redirect+stall
    vecs[21] = mk(0, 0, 19'h0,      1, 19'h00200, 0, 19'h0);
    vecs[22] = mk(0, 0, 19'h0,      1, 19'h00201, 1, 19'h00200);
    vecs[23] = mk(0, 0, 19'h0,      1, 19'h00202, 1, 19'h00201);
    vecs[24] = mk(0, 1, 19'h7FFFE,  0, 19'h00203, 0, 19'h0);     // wrap target
    vecs[25] = mk(0, 0, 19'h0,      1, 19'h7FFFE, 0, 19'h0);
    vecs[26] = mk(0, 0, 19'h0,      1, 19'h7FFFF, 1, 19'h7FFFE);
    vecs[27] = mk(0, 0, 19'h0,      1, 19'h00000, 1, 19'h7FFFF);
    vecs[28] = mk(0, 0, 19'h0,      1, 19'h00001, 1, 19'h00000);
    vecs[29] = mk(0, 0, 19'h0,      1, 19'h00002, 1, 19'h00001);

    rst = 1'b0; stall_d = 1'b0; pcsrc_e = 1'b0; pctarget_e = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset imem_en",   {18'b0, imem_en}, 19'h0);
    chk("reset valid_d",   {18'b0, valid_d}, 19'h0);
    chk("reset pc_d",      pc_d,      19'h0);
    chk("reset instr_d",   instr_d,   19'h0);
    chk("reset pcplus1_d", pcplus1_d, 19'h0);
    rst = 1'b1;

    for (int unsigned i = 0; i < NV; i++) begin
      stall_d    = vecs[i].stall;
      pcsrc_e    = vecs[i].pcsrc;
      pctarget_e = vecs[i].target;
      #4;
      chk($sformatf("v%0d imem_en", i),   {18'b0, imem_en}, {18'b0, vecs[i].exp_en});
      chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].exp_addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valid_d", i), {18'b0, valid_d}, {18'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d pc_d", i),      pc_d,      vecs[i].exp_pc);
        chk($sformatf("v%0d instr_d", i),   instr_d,   memword(vecs[i].exp_pc));
        chk($sformatf("v%0d pcplus1_d", i), pcplus1_d, vecs[i].exp_pc + 19'h1);
      end
    end

    // Reset in the middle of a running stream.
    stall_d = 1'b0; pcsrc_e = 1'b0; pctarget_e = '0;
    rst = 1'b0;
    #4;
    chk("midrst imem_en", {18'b0, imem_en}, 19'h0);
    @(posedge clk); #1;
    chk("midrst valid_d",   {18'b0, valid_d}, 19'h0);
    chk("midrst pc_d",      pc_d,      19'h0);
    chk("midrst instr_d",   instr_d,   19'h0);
    chk("midrst pcplus1_d", pcplus1_d, 19'h0);
    rst = 1'b1;
    #4;
    chk("restart imem_en",   {18'b0, imem_en}, 19'h1);
    chk("restart imem_addr", imem_addr, 19'h0);
    @(posedge clk); #1;
    chk("restart bubble", {18'b0, valid_d}, 19'h0);
    #4;
    chk("restart imem_addr2", imem_addr, 19'h1);
    @(posedge clk); #1;
    chk("restart valid_d",   {18'b0, valid_d}, 19'h1);
    chk("restart pc_d",      pc_d,      19'h0);
    chk("restart instr_d",   instr_d,   19'h40000);
    chk("restart pcplus1_d", pcplus1_d, 19'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
